dmem_access_ctrl: RTL and testbench

Sequences data-memory transactions for the MEM stage of the dual-issue MIPS pipeline over an SRAM-like req/addr_ok/data_ok bus. Issue slot 1 is the only memory slot. The block performs these steps:
- Captures the slot-1 load/store.
- Generates the word address, size, byte strobes and lane-shifted write data.
- Stalls the pipeline until the access completes.
- Holds the raw read word for the MEM load-alignment logic.
- Drains in-flight transactions on an exception flush.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_access_ctrl_if.sv | 38 +++
 rtl/dmem_wstrb_gen.sv | 50 +++++
 rtl/dmem_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// Covers the controller FSM states, bus size / unaligned-kind codes and the captured request record.
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD,
        DRAIN
    } dmem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] LR_NONE  = 2'd0;
    localparam logic [1:0] LR_LEFT  = 2'd1;
    localparam logic [1:0] LR_RIGHT = 2'd2;

    // Request fields latched when a slot-1 load/store is accepted.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [1:0]  lr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// SRAM-like data bus between the MEM-stage controller (master) and data memory (slave).
interface dmem_access_ctrl_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );

endinterface

// File: rtl/dmem_wstrb_gen.sv
// Combinational byte-strobe and store-lane generator for aligned and LWL/SWL/LWR/SWR-style accesses.
// Loads produce no strobes and zero write data.
module dmem_wstrb_gen
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lr,
    input  logic [1:0]  a,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_shifted
);

    // Left stores fill the low bytes up to a (shift right by 8*(3-a) == {~a,3'b0});
    // right stores fill from byte a upward (shift left by 8*a).
    always_comb begin
        wstrb         = 4'b0000;
        wdata_shifted = 32'h0000_0000;
        if (we) begin
            case (lr)
                LR_LEFT: begin
                    wstrb         = 4'b1111 >> (~a);
                    wdata_shifted = wdata >> {~a, 3'b000};
                end
                LR_RIGHT: begin
                    wstrb         = 4'b1111 << a;
                    wdata_shifted = wdata << {a, 3'b000};
                end
                default: begin
                    case (size)
                        SIZE_BYTE: begin
                            wstrb         = 4'b0001 << a;
                            wdata_shifted = {4{wdata[7:0]}};
                        end
                        SIZE_HALF: begin
                            wstrb         = 4'b0011 << {a[1], 1'b0};
                            wdata_shifted = {2{wdata[15:0]}};
                        end
                        default: begin
                            wstrb         = 4'b1111;
                            wdata_shifted = wdata;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one slot-1 load/store at a time on the req/addr_ok/data_ok
// bus, stalls the pipeline until it completes, holds the raw read word and drains flushed accesses.
module dmem_access_ctrl
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_lr_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        exc_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        stallreq_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    dmem_access_ctrl_if.master bus
);

    dmem_state_e state_q;
    dmem_state_e state_d;
    logic        flushed_q;
    logic        flushed_d;
    mem_req_t    req_q;
    logic [31:0] rdata_q;
    logic        capture;
    logic        load_rdata;
    logic        start;
    logic        flush_seen;
    logic        issuing;
    logic [3:0]  gen_wstrb;
    logic [31:0] gen_wdata;

    assign start      = req_valid_i & ~exc_i & ~flush_i;
    assign flush_seen = flushed_q | flush_i;
    assign issuing    = (state_q == ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flushed_q <= flushed_d;
        end
    end

    // A request, once raised, is never withdrawn: a flush only marks it so its data_ok is swallowed.
    always_comb begin
        state_d    = state_q;
        flushed_d  = flushed_q;
        capture    = 1'b0;
        load_rdata = 1'b0;
        stallreq_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ADDR;
                    flushed_d  = 1'b0;
                    capture    = 1'b1;
                    stallreq_o = 1'b1;
                end
            end
            ADDR: begin
                stallreq_o = flushed_q ? req_valid_i : 1'b1;
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        flushed_d = 1'b0;
                        if (flush_seen) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = HOLD;
                            load_rdata = 1'b1;
                        end
                    end else begin
                        state_d   = flush_seen ? DRAIN : DATA;
                        flushed_d = flush_seen;
                    end
                end else begin
                    flushed_d = flush_seen;
                end
            end
            DATA: begin
                stallreq_o = ~flushed_q;
                if (flush_i) begin
                    state_d   = bus.data_data_ok ? IDLE : DRAIN;
                    flushed_d = ~bus.data_data_ok;
                end else if (bus.data_data_ok) begin
                    state_d    = HOLD;
                    load_rdata = 1'b1;
                end
            end
            HOLD: begin
                if (!stall_i || flush_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                stallreq_o = req_valid_i;
                if (bus.data_data_ok) begin
                    state_d   = IDLE;
                    flushed_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                flushed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            rdata_q <= 32'h0000_0000;
        end else begin
            if (capture) begin
                req_q.we    <= req_we_i;
                req_q.size  <= req_size_i;
                req_q.lr    <= req_lr_i;
                req_q.addr  <= req_addr_i;
                req_q.wdata <= req_wdata_i;
            end
            if (load_rdata) begin
                rdata_q <= bus.data_rdata;
            end
        end
    end

    dmem_wstrb_gen u_wstrb_gen (
        .size          (req_q.size),
        .lr            (req_q.lr),
        .a             (req_q.addr[1:0]),
        .we            (req_q.we),
        .wdata         (req_q.wdata),
        .wstrb         (gen_wstrb),
        .wdata_shifted (gen_wdata)
    );

    // Bus fields come only from the latched request, so they cannot move while waiting for addr_ok.
    assign bus.data_req   = issuing;
    assign bus.data_wr    = issuing & req_q.we;
    assign bus.data_size  = issuing ? ((req_q.lr != LR_NONE) ? SIZE_WORD : req_q.size) : 2'b00;
    assign bus.data_addr  = issuing ? ((req_q.lr != LR_NONE) ? word_align(req_q.addr) : req_q.addr)
                                    : 32'h0000_0000;
    assign bus.data_wstrb = issuing ? gen_wstrb : 4'b0000;
    assign bus.data_wdata = issuing ? gen_wdata : 32'h0000_0000;

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios with literal expectations, then randomized traffic,
// every cycle compared against a transaction-level model of the controller.
module tb_dmem_access_ctrl;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_fields_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [1:0]  req_lr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        exc;
    logic        flush;
    logic        stall;
    logic        stallreq;
    logic [31:0] rdata;
    logic        rdata_valid;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_we_i      (req_we),
        .req_size_i    (req_size),
        .req_lr_i      (req_lr),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .exc_i         (exc),
        .flush_i       (flush),
        .stall_i       (stall),
        .stallreq_o    (stallreq),
        .rdata_o       (rdata),
        .rdata_valid_o (rdata_valid),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Model: an outstanding transaction (busy), whether its address was taken, whether it was
    // flushed, whether a completed load is being held, and the last delivered read word.
    bit          m_busy;
    bit          m_addr_acc;
    bit          m_flushed;
    bit          m_hold;
    logic [31:0] m_rdata;
    bus_fields_t m_fields;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic bus_fields_t expFields(input logic we, input logic [1:0] size,
                                              input logic [1:0] lr, input logic [31:0] addr,
                                              input logic [31:0] wdata);
        bus_fields_t f;
        int          a;
        logic [3:0]  left_tbl[4];
        logic [3:0]  right_tbl[4];
        left_tbl  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        right_tbl = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
        a         = int'(addr[1:0]);
        f.wr      = we;
        if (lr != 2'd0) begin
            f.addr = addr & 32'hFFFF_FFFC;
            f.size = 2'd2;
        end else begin
            f.addr = addr;
            f.size = size;
        end
        f.wstrb = 4'b0000;
        f.wdata = 32'h0;
        if (we) begin
            if (lr == 2'd1) begin
                f.wstrb = left_tbl[a];
                f.wdata = wdata >> (8 * (3 - a));
            end else if (lr == 2'd2) begin
                f.wstrb = right_tbl[a];
                f.wdata = wdata << (8 * a);
            end else if (size == 2'd0) begin
                f.wstrb = 4'b0001 << a;
                f.wdata = {4{wdata[7:0]}};
            end else if (size == 2'd1) begin
                f.wstrb = 4'b0011 << (2 * (a / 2));
                f.wdata = {2{wdata[15:0]}};
            end else begin
                f.wstrb = 4'b1111;
                f.wdata = wdata;
            end
        end
        return f;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [1:0] size,
                                 input logic [1:0] lr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic e, input logic f,
                                 input logic s);
        req_valid = v;
        req_we    = we;
        req_size  = size;
        req_lr    = lr;
        req_addr  = addr;
        req_wdata = wdata;
        exc       = e;
        flush     = f;
        stall     = s;
    endtask

    task automatic setBus(input logic aok, input logic dok, input logic [31:0] rd);
        bus.data_addr_ok = aok;
        bus.data_data_ok = dok;
        bus.data_rdata   = rd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        setBus(1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkOutput();
        bus_fields_t f;
        logic        exp_req;
        logic        exp_stall;
        exp_req   = m_busy && !m_addr_acc;
        f         = exp_req ? m_fields : '0;
        exp_stall = (!m_busy && !m_hold && req_valid && !exc && !flush) ||
                    (m_busy && (!m_flushed || req_valid));
        cmp("stallreq",    32'(stallreq),       32'(exp_stall));
        cmp("rdata_valid", 32'(rdata_valid),    32'(m_hold));
        cmp("rdata",       rdata,               m_rdata);
        cmp("data_req",    32'(bus.data_req),   32'(exp_req));
        cmp("data_wr",     32'(bus.data_wr),    32'(f.wr));
        cmp("data_size",   32'(bus.data_size),  32'(f.size));
        cmp("data_addr",   bus.data_addr,       f.addr);
        cmp("data_wstrb",  32'(bus.data_wstrb), 32'(f.wstrb));
        cmp("data_wdata",  bus.data_wdata,      f.wdata);
    endtask

    task automatic atSample();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic advance();
        bit          nb;
        bit          na;
        bit          nf;
        bit          nh;
        bit          fl;
        logic [31:0] nr;
        bus_fields_t nfld;
        nb   = m_busy;
        na   = m_addr_acc;
        nf   = m_flushed;
        nh   = m_hold;
        nr   = m_rdata;
        nfld = m_fields;
        if (rst) begin
            nb = 0; na = 0; nf = 0; nh = 0; nr = 32'h0;
        end else if (m_hold) begin
            if (!stall || flush) nh = 0;
        end else if (!m_busy) begin
            if (req_valid && !exc && !flush) begin
                nb   = 1; na = 0; nf = 0;
                nfld = expFields(req_we, req_size, req_lr, req_addr, req_wdata);
            end
        end else begin
            fl = m_flushed || flush;
            if (!m_addr_acc && !bus.data_addr_ok) begin
                nf = fl;
            end else begin
                na = 1;
                if (bus.data_data_ok) begin
                    nb = 0;
                    nf = 0;
                    if (!fl) begin
                        nh = 1;
                        nr = bus.data_rdata;
                    end
                end else begin
                    nf = fl;
                end
            end
        end
        @(posedge clk);
        #1;
        m_busy     = nb;
        m_addr_acc = na;
        m_flushed  = nf;
        m_hold     = nh;
        m_rdata    = nr;
        m_fields   = nfld;
    endtask

    task automatic tick();
        atSample();
        advance();
    endtask

    initial begin
        m_busy = 0; m_addr_acc = 0; m_flushed = 0; m_hold = 0;
        m_rdata = 32'h0; m_fields = '0;
        rst = 1'b1;
        idle();
        advance();
        advance();
        rst = 1'b0;

        // Reset state
        atSample();
        cmp("rst_stallreq", 32'(stallreq), 32'd0);
        cmp("rst_req",      32'(bus.data_req), 32'd0);
        cmp("rst_valid",    32'(rdata_valid), 32'd0);
        cmp("rst_rdata",    rdata, 32'h0);
        advance();

        // LW, addr_ok and data_ok together
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0);
        atSample();
        cmp("lw_t0_stall", 32'(stallreq), 32'd1);
        cmp("lw_t0_req",   32'(bus.data_req), 32'd0);
        advance();
        setBus(1'b1, 1'b1, 32'hDEAD_BEEF);
        atSample();
        cmp("lw_t1_req",   32'(bus.data_req), 32'd1);
        cmp("lw_t1_addr",  bus.data_addr, 32'h8000_0010);
        cmp("lw_t1_stall", 32'(stallreq), 32'd1);
        advance();
        setBus(1'b0, 1'b0, 32'h0);
        atSample();
        cmp("lw_t2_valid", 32'(rdata_valid), 32'd1);
        cmp("lw_t2_rdata", rdata, 32'hDEAD_BEEF);
        cmp("lw_t2_stall", 32'(stallreq), 32'd0);
        cmp("lw_t2_req",   32'(bus.data_req), 32'd0);
        advance();
        idle();
        atSample();
        cmp("lw_t3_valid", 32'(rdata_valid), 32'd0);
        advance();

        // SB at byte lane 3
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd0, 32'h1000_0013, 32'h0000_00A5, 1'b0, 1'b0, 1'b0);
        tick();
        atSample();
        cmp("sb_wstrb", 32'(bus.data_wstrb), 32'h8);
        cmp("sb_wdata", bus.data_wdata, 32'hA5A5_A5A5);
        cmp("sb_size",  32'(bus.data_size), 32'd0);
        cmp("sb_wr",    32'(bus.data_wr), 32'd1);
        cmp("sb_addr",  bus.data_addr, 32'h1000_0013);
        advance();
        setBus(1'b1, 1'b0, 32'h0);
        tick();
        setBus(1'b0, 1'b1, 32'h0);
        tick();
        setBus(1'b0, 1'b0, 32'h0);
        tick();
        idle();
        tick();

        // SWL with a=1
        applyStimulus(1'b1, 1'b1, 2'd2, 2'd1, 32'h1000_0021, 32'h1122_3344, 1'b0, 1'b0, 1'b0);
        tick();
        setBus(1'b1, 1'b1, 32'h0);
        atSample();
        cmp("swl_wstrb", 32'(bus.data_wstrb), 32'h3);
        cmp("swl_wdata", bus.data_wdata, 32'h0000_1122);
        cmp("swl_addr",  bus.data_addr, 32'h1000_0020);
        cmp("swl_size",  32'(bus.data_size), 32'd2);
        advance();
        setBus(1'b0, 1'b0, 32'h0);
        atSample();
        cmp("swl_valid", 32'(rdata_valid), 32'd1);
        advance();
        idle();
        tick();

        // Flush while waiting for a late addr_ok; the data_ok is swallowed
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0040, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0040, 32'h0, 1'b0, 1'b1, 1'b0);
        atSample();
        cmp("fl_t2_req", 32'(bus.data_req), 32'd1);
        advance();
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0080, 32'h0, 1'b0, 1'b0, 1'b0);
        atSample();
        cmp("fl_t3_req",   32'(bus.data_req), 32'd1);
        cmp("fl_t3_addr",  bus.data_addr, 32'h8000_0040);
        cmp("fl_t3_stall", 32'(stallreq), 32'd1);
        advance();
        setBus(1'b1, 1'b0, 32'h0);
        atSample();
        cmp("fl_t4_req", 32'(bus.data_req), 32'd1);
        advance();
        setBus(1'b0, 1'b1, 32'h1234_5678);
        atSample();
        cmp("fl_drain_stall", 32'(stallreq), 32'd1);
        cmp("fl_drain_valid", 32'(rdata_valid), 32'd0);
        cmp("fl_drain_req",   32'(bus.data_req), 32'd0);
        advance();
        setBus(1'b0, 1'b0, 32'h0);
        atSample();
        cmp("fl_next_stall", 32'(stallreq), 32'd1);
        cmp("fl_next_valid", 32'(rdata_valid), 32'd0);
        advance();
        setBus(1'b1, 1'b1, 32'hCAFE_F00D);
        atSample();
        cmp("fl_next_addr", bus.data_addr, 32'h8000_0080);
        advance();
        setBus(1'b0, 1'b0, 32'h0);
        atSample();
        cmp("fl_next_rdata", rdata, 32'hCAFE_F00D);
        advance();
        idle();
        tick();

        // Load completes while the pipeline is held by another source
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0100, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        setBus(1'b1, 1'b1, 32'h0BAD_F00D);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0100, 32'h0, 1'b0, 1'b0, 1'b1);
            setBus(1'b0, 1'b0, $urandom);
            atSample();
            cmp("hold_valid", 32'(rdata_valid), 32'd1);
            cmp("hold_rdata", rdata, 32'h0BAD_F00D);
            cmp("hold_stall", 32'(stallreq), 32'd0);
            advance();
        end
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0100, 32'h0, 1'b0, 1'b0, 1'b0);
        setBus(1'b0, 1'b0, 32'h0);
        atSample();
        cmp("hold_last_valid", 32'(rdata_valid), 32'd1);
        advance();
        idle();
        atSample();
        cmp("hold_done_valid", 32'(rdata_valid), 32'd0);
        advance();

        // Excepting misaligned SW issues nothing
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd2, 2'd0, 32'h1000_0002, 32'h55, 1'b1, 1'b0, 1'b0);
            atSample();
            cmp("exc_req",   32'(bus.data_req), 32'd0);
            cmp("exc_stall", 32'(stallreq), 32'd0);
            advance();
        end
        idle();
        tick();

        // Reset in the middle of DATA
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0200, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        setBus(1'b1, 1'b0, 32'h0);
        tick();
        setBus(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        atSample();
        cmp("rstd_pre_stall", 32'(stallreq), 32'd1);
        advance();
        rst = 1'b0;
        idle();
        atSample();
        cmp("rstd_stall", 32'(stallreq), 32'd0);
        cmp("rstd_req",   32'(bus.data_req), 32'd0);
        cmp("rstd_valid", 32'(rdata_valid), 32'd0);
        cmp("rstd_rdata", rdata, 32'h0);
        advance();

        // Randomized traffic with a protocol-legal memory responder
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_valid = ($urandom_range(0, 9) < 6);
            req_we    = 1'($urandom_range(0, 1));
            req_size  = 2'($urandom_range(0, 2));
            req_lr    = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 2));
            req_addr  = $urandom;
            req_wdata = $urandom;
            exc       = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 99) < 8);
            stall     = ($urandom_range(0, 3) == 0);
            bus.data_addr_ok = m_busy && !m_addr_acc && ($urandom_range(0, 99) < 40);
            bus.data_data_ok = m_busy && (m_addr_acc || bus.data_addr_ok) &&
                               ($urandom_range(0, 99) < 40);
            bus.data_rdata   = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
